extend: RTL and testbench
=========================

Name: extend

Overview:
- Stream widener: the inverse of the team's `saturate` narrower.
- Accepts signed ARGW-bit words on the `arg_` stream and emits signed RESW-bit words on the `res_` stream.
- Sign-extends and optionally left-aligns each word by SHIFT fractional bits. `saturate` followed by `extend` (or the reverse) round-trips in-range values.
- Output is fully registered behind a 2-entry skid buffer, so the block sits between datapath stages at full throughput without a combinational ready path.

Parameters:
- ARGW, 16, input word width (signed, two's complement).
- RESW, 24, output word width; elaboration error unless RESW >= ARGW + SHIFT.
- SHIFT, 0, left shift applied after sign extension (fixed-point alignment). Vacated LSBs are zero.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- arg_data  input  ARGW  input word.
- arg_valid  input  1  input word valid.
- arg_ready  output  1  block can accept a word; registered output.
- res_data  output  RESW  output word; registered.
- res_valid  output  1  output word valid; registered.
- res_ready  input  1  downstream accepts output.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where valid && ready on the same stream. No other combination moves data.
- Arithmetic: res = {sign-extend(arg) to RESW-SHIFT bits, SHIFT zeros}. This is a pure bit mapping with no overflow possible, given the parameter check.
- Storage: main register (drives res_data/res_valid) plus one skid register.
- State machine, by occupancy:
  - EMPTY: res_valid=0, arg_ready=1.
    - Input transfer -> ONE; the word loads into main.
  - ONE: res_valid=1, arg_ready=1.
    - Input only -> TWO; the word loads into skid.
    - Output only -> EMPTY.
    - Both -> stay ONE; main takes the new word.
    - Neither -> hold.
  - TWO: res_valid=1, arg_ready=0.
    - Output transfer -> ONE; skid moves into main.
    - No input is possible in TWO.
- Latency: 1 cycle. A word accepted at edge N is presented on res_data after edge N, and can transfer at edge N+1.
- Throughput: 1 word/cycle sustained while res_ready=1.
- Stability:
  - res_data and res_valid do not change while res_valid=1 && res_ready=0.
  - res_valid never drops without a transfer.
- Ordering: strict FIFO. No word is lost or duplicated under any res_ready pattern.
- Reset values (while rst=1 and on the first cycle after): res_valid=0, res_data=0, arg_ready=0.
  - arg_ready rises on the first edge after rst deasserts.
  - Handshakes presented while rst=1 are ignored.
- Reset mid-operation: both registers are discarded immediately (state -> EMPTY). Any word held is lost and no partial transfer is completed.
- arg_data is sampled only on a transfer; X on arg_data while arg_valid=0 must not propagate.

Test Plan:
- Sign extension, ARGW=16, RESW=24, SHIFT=0. Send 16'h00ff, 16'hff00, 16'h7fff, 16'h8000 -> receive 24'h0000ff, 24'hffff00, 24'h007fff, 24'hff8000, in order.
- Alignment, SHIFT=4. Send 16'h8000 and 16'h0001 -> receive 24'hf80000 and 24'h000010.
- Backpressure:
  - With res_ready=0, offer 3 words -> 2 accepted, arg_ready=0 on the cycle after the second. res_data holds the first word stable.
  - Raise res_ready -> all 3 words out in order, none lost.
- Throughput: 64 back-to-back words with res_ready=1 -> the first result one cycle after the first accept, then one result per cycle with no bubbles. Random res_ready toggling -> output sequence equals input sequence.
- Reset mid-operation: fill to TWO, pulse rst for 1 cycle -> res_valid=0 and arg_ready=0 during reset, no stale word emitted afterwards, and a fresh 16'h1234 yields 24'h001234.
- Round trip: chain `extend` (16->24) into `saturate` (24->16) and send 16'h8000, 16'h7fff, 16'h0000, 16'hffff -> identical values out.

Source files
------------

// File: rtl/extend_if.sv
// Stream bundle for the extend widener: the narrow arg_ input stream and the wide res_ output stream.
// master drives arg_ and accepts res_; slave is the widener side.
interface extend_if #(
  parameter int ARGW = 16,
  parameter int RESW = 24
);
  logic [ARGW-1:0] arg_data;
  logic            arg_valid;
  logic            arg_ready;
  logic [RESW-1:0] res_data;
  logic            res_valid;
  logic            res_ready;

  modport master (
    output arg_data, arg_valid, res_ready,
    input  arg_ready, res_data, res_valid
  );

  modport slave (
    input  arg_data, arg_valid, res_ready,
    output arg_ready, res_data, res_valid
  );
endinterface

// File: rtl/extend.sv
// Signed stream widener: sign-extends ARGW-bit words to RESW bits, then left-aligns them by SHIFT.
// The output is fully registered behind a main + skid pair, so arg_ready has no combinational path from res_ready.
module extend #(
  parameter int ARGW  = 16,
  parameter int RESW  = 24,
  parameter int SHIFT = 0
) (
  input  logic     clk,
  input  logic     rst,
  extend_if.slave  bus
);

  if (RESW < ARGW + SHIFT) begin : g_param_err
    $error("extend: RESW must be at least ARGW + SHIFT");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [RESW-1:0] main_reg, skid_reg, main_next;
  logic [RESW-1:0] widened;
  logic            arg_ready_reg;
  logic            in_fire, out_fire, load_main, load_skid;

  // Sign extension first, then the shift; vacated LSBs fill with zeros.
  assign widened = RESW'($signed(bus.arg_data)) << SHIFT;

  always_comb begin
    in_fire    = bus.arg_valid && arg_ready_reg;
    out_fire   = (state_reg != EMPTY) && bus.res_ready;
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    main_next  = widened;
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // arg_ready is low here, so only the drain of main can happen.
        if (out_fire) begin
          state_next = ONE;
          load_main  = 1'b1;
          main_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      arg_ready_reg <= 1'b0;
      main_reg      <= '0;
      skid_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      arg_ready_reg <= (state_next != TWO);
      if (load_main) main_reg <= main_next;
      if (load_skid) skid_reg <= widened;
    end
  end

  assign bus.arg_ready = arg_ready_reg;
  assign bus.res_valid = (state_reg != EMPTY);
  assign bus.res_data  = main_reg;

endmodule

// File: tb/tb_extend.sv
// Randomised and directed bench for extend: a SHIFT=0 and a SHIFT=4 instance share one input stream
// and are scored against an arithmetic reference plus a saturating narrower model for the round trip.
module tb_extend;

  logic        clk;
  logic        rst;
  logic [15:0] arg_data;
  logic        arg_valid;
  logic        res_ready;
  int          rr_mode;   // 0: res_ready low, 1: high, 2: random
  int          cyc;
  int          total;
  int          bad;

  logic [23:0] exp0[$], exp4[$], rx0[$], rx4[$];
  int          acc_cyc[$], out_cyc[$];
  logic        stall0, stall4;
  logic [23:0] held0, held4;

  extend_if #(.ARGW(16), .RESW(24)) b0 ();
  extend_if #(.ARGW(16), .RESW(24)) b4 ();

  assign b0.arg_data  = arg_data;
  assign b0.arg_valid = arg_valid;
  assign b0.res_ready = res_ready;
  assign b4.arg_data  = arg_data;
  assign b4.arg_valid = arg_valid;
  assign b4.res_ready = res_ready;

  extend #(.ARGW(16), .RESW(24), .SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  extend #(.ARGW(16), .RESW(24), .SHIFT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rr_mode == 2) res_ready = 1'($urandom_range(0, 1));
    else              res_ready = (rr_mode == 1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: value of the signed input times 2^sh, reduced to 24 bits.
  function automatic logic [23:0] ref_ext(input logic [15:0] a, input int sh);
    int v;
    v = int'($signed(a));
    v = v * (1 << sh);
    return v[23:0];
  endfunction

  // Model of the saturating 24->16 narrower used for the round trip.
  function automatic logic [15:0] sat16(input logic [23:0] r);
    int v;
    v = int'($signed(r));
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  // Scoreboard: handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp0.delete();
      exp4.delete();
      stall0 = 1'b0;
      stall4 = 1'b0;
    end else begin
      if (stall0) begin
        check("hold_valid0", 32'(b0.res_valid), 32'd1);
        check("hold_data0", 32'(b0.res_data), 32'(held0));
      end
      if (stall4) begin
        check("hold_data4", 32'(b4.res_data), 32'(held4));
      end
      if (arg_valid && b0.arg_ready) begin
        exp0.push_back(ref_ext(arg_data, 0));
        exp4.push_back(ref_ext(arg_data, 4));
        acc_cyc.push_back(cyc);
      end
      if (b0.res_valid && res_ready) begin
        if (exp0.size() == 0) check("spurious0", 32'(b0.res_data), 32'hdead);
        else                  check("data0", 32'(b0.res_data), 32'(exp0.pop_front()));
        rx0.push_back(b0.res_data);
        out_cyc.push_back(cyc);
      end
      if (b4.res_valid && res_ready) begin
        if (exp4.size() == 0) check("spurious4", 32'(b4.res_data), 32'hdead);
        else                  check("data4", 32'(b4.res_data), 32'(exp4.pop_front()));
        rx4.push_back(b4.res_data);
      end
      stall0 = b0.res_valid && !res_ready;
      stall4 = b4.res_valid && !res_ready;
      held0  = b0.res_data;
      held4  = b4.res_data;
    end
  end

  task automatic put(input logic [15:0] w);
    int n;
    n = 0;
    arg_data  = w;
    arg_valid = 1'b1;
    @(negedge clk);
    while (!b0.arg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("put_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    arg_valid = 1'b0;
    arg_data  = 'x;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rr_mode = 1;
    @(posedge clk);
    #1;
    while ((b0.res_valid || b4.res_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
  endtask

  logic [15:0] se_in [4] = '{16'h00ff, 16'hff00, 16'h7fff, 16'h8000};
  logic [23:0] se_exp[4] = '{24'h0000ff, 24'hffff00, 24'h007fff, 24'hff8000};
  logic [15:0] rt_in [4] = '{16'h8000, 16'h7fff, 16'h0000, 16'hffff};
  logic [15:0] bp_in [3] = '{16'h0123, 16'hfedc, 16'h5a5a};
  logic [23:0] bp_exp[3] = '{24'h000123, 24'hfffedc, 24'h005a5a};

  initial begin
    int base, k;
    logic fired;
    total = 0; bad = 0; cyc = 0; rr_mode = 1;
    stall0 = 1'b0; stall4 = 1'b0; held0 = '0; held4 = '0;
    rst = 1'b1; arg_valid = 1'b1; arg_data = 16'h7777; res_ready = 1'b1;

    // Reset: handshakes offered during reset are ignored.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(b0.res_valid), 32'd0);
    check("rst_data", 32'(b0.res_data), 32'd0);
    check("rst_ready", 32'(b0.arg_ready), 32'd0);
    arg_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_low", 32'(b0.arg_ready), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_ready_high", 32'(b0.arg_ready), 32'd1);
    check("post_rst_empty", 32'(b0.res_valid), 32'd0);

    // Sign extension and alignment.
    base = rx0.size();
    for (int i = 0; i < 4; i++) put(se_in[i]);
    drain();
    check("se_count", 32'(rx0.size() - base), 32'd4);
    if (rx0.size() == base + 4)
      for (int i = 0; i < 4; i++) check("se_word", 32'(rx0[base + i]), 32'(se_exp[i]));
    base = rx4.size();
    put(16'h8000);
    put(16'h0001);
    drain();
    if (rx4.size() == base + 2) begin
      check("align_8000", 32'(rx4[base]), 32'h00f80000);
      check("align_0001", 32'(rx4[base + 1]), 32'h00000010);
    end else check("align_count", 32'(rx4.size() - base), 32'd2);

    // Backpressure: only two words fit.
    rr_mode = 0;
    @(posedge clk);
    #1;
    base = rx0.size();
    k = 0;
    repeat (6) begin
      arg_valid = 1'b1;
      arg_data  = bp_in[k];
      @(negedge clk);
      fired = b0.arg_ready;
      @(posedge clk);
      #1;
      if (fired) k++;
    end
    check("bp_accepted", 32'(k), 32'd2);
    check("bp_ready_low", 32'(b0.arg_ready), 32'd0);
    check("bp_head", 32'(b0.res_data), 32'(bp_exp[0]));
    rr_mode = 1;
    for (int n = 0; n < 20 && k < 3; n++) begin
      @(negedge clk);
      fired = b0.arg_ready;
      @(posedge clk);
      #1;
      if (fired) k++;
    end
    arg_valid = 1'b0;
    check("bp_third_accepted", 32'(k), 32'd3);
    drain();
    check("bp_count", 32'(rx0.size() - base), 32'd3);
    if (rx0.size() == base + 3)
      for (int i = 0; i < 3; i++) check("bp_order", 32'(rx0[base + i]), 32'(bp_exp[i]));

    // Throughput: 64 back-to-back words, no bubbles.
    acc_cyc.delete();
    out_cyc.delete();
    for (int i = 0; i < 64; i++) put(16'($urandom));
    drain();
    check("tp_count", 32'(out_cyc.size()), 32'd64);
    if (out_cyc.size() == 64 && acc_cyc.size() == 64)
      for (int i = 0; i < 64; i++) check("tp_cycle", 32'(out_cyc[i]), 32'(acc_cyc[0] + 1 + i));

    // Random traffic with random backpressure.
    rr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      put(16'($urandom));
    end
    drain();
    check("rand_leftover0", 32'(exp0.size()), 32'd0);
    check("rand_leftover4", 32'(exp4.size()), 32'd0);

    // Reset while holding two words.
    rr_mode = 0;
    @(posedge clk);
    #1;
    put(16'h1111);
    put(16'h2222);
    check("fill_two_ready", 32'(b0.arg_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(b0.res_valid), 32'd0);
    check("midrst_ready", 32'(b0.arg_ready), 32'd0);
    rst = 1'b0;
    rr_mode = 1;
    base = rx0.size();
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_stale", 32'(rx0.size()), 32'(base));
    put(16'h1234);
    drain();
    if (rx0.size() == base + 1) check("midrst_fresh", 32'(rx0[base]), 32'h00001234);
    else check("midrst_fresh_count", 32'(rx0.size() - base), 32'd1);

    // Round trip through the saturating narrower model.
    base = rx0.size();
    for (int i = 0; i < 4; i++) put(rt_in[i]);
    drain();
    if (rx0.size() == base + 4)
      for (int i = 0; i < 4; i++) check("roundtrip", 32'(sat16(rx0[base + i])), 32'(rt_in[i]));
    else check("roundtrip_count", 32'(rx0.size() - base), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
